vend_scheduler: RTL and testbench

Shares one product dispenser and one change-return unit between two coin kiosks.
- Each kiosk accumulates its own credit in taka.
- The scheduler picks one ready kiosk at a time, round-robin, and sequences the transaction: dispense handshake, then change return.
- Sits between the kiosk coin acceptors and the shared mechanical units.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/vend_credit_acc.sv | 51 +++++
 rtl/vend_scheduler.sv | 129 ++++++++++++
 tb/tb_vend_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the two-kiosk vending scheduler: coin codes, FSM encodings, pricing defaults.
// Coin codes outside COIN_5/COIN_10 are illegal and map to a zero amount.
package vend_pkg;

    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DISPENSE = 2'd1;
    localparam logic [1:0] CHANGE   = 2'd2;

    localparam int PRICE_DEF      = 15;
    localparam int MAX_CREDIT_DEF = 30;
    localparam int TIMEOUT_DEF    = 8;

    function automatic logic [4:0] coin_amount(input logic [1:0] code);
        case (code)
            COIN_5:  return 5'd5;
            COIN_10: return 5'd10;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Per-kiosk credit register with coin legality/overflow check and refund latch; coins update credit
// at the edge, rejects pulse one cycle later; no coins are taken while the kiosk holds the grant.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = MAX_CREDIT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       cancel,
    input  logic       busy,
    input  logic       clear,
    output logic [4:0] credit,
    output logic       cancel_pend,
    output logic       coin_reject
);

    logic [4:0] amount;
    logic [5:0] sum;
    logic       accept;

    // Six-bit sum so the overflow compare cannot wrap.
    always_comb begin
        amount = coin_amount(coin_val);
        sum    = {1'b0, credit} + {1'b0, amount};
        accept = coin_valid && (amount != 5'd0) && !busy && !cancel
                 && (sum <= 6'(MAX_CREDIT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            credit      <= 5'd0;
            cancel_pend <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_valid && !accept;
            if (clear) begin
                credit      <= 5'd0;
                cancel_pend <= 1'b0;
            end else begin
                if (accept)
                    credit <= sum[4:0];
                if (cancel && !busy && (credit != 5'd0))
                    cancel_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_scheduler.sv
// Round-robin arbiter sharing one dispenser and one change unit between two coin kiosks.
// Grant one cycle after a kiosk becomes ready; dispenser stall is bounded by TIMEOUT, then full refund.
module vend_scheduler
    import vend_pkg::*;
#(
    parameter int PRICE      = PRICE_DEF,
    parameter int MAX_CREDIT = MAX_CREDIT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] coin_valid,
    input  logic [3:0] coin_val,
    input  logic [1:0] cancel,
    output logic [1:0] coin_reject,
    output logic [4:0] credit0,
    output logic [4:0] credit1,
    output logic [1:0] busy,
    output logic       disp_req,
    output logic       disp_kiosk,
    input  logic       disp_ack,
    output logic       chg_valid,
    output logic [4:0] chg_amt,
    output logic       chg_kiosk,
    output logic       fault
);

    localparam int         TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [4:0] PRICE_C = 5'(PRICE);

    logic [1:0]    state;
    logic          grant;
    logic          rr_ptr;
    logic          refund;
    logic [TW-1:0] timer;
    logic [4:0]    chg_reg;

    logic [4:0]    credit [2];
    logic [1:0]    pend;
    logic [1:0]    clear;
    logic [1:0]    ready;
    logic          pick;
    logic [4:0]    credit_g;
    logic          timed_out;
    logic          in_change;
    logic [4:0]    change_amount;

    for (genvar i = 0; i < 2; i++) begin : g_acc
        vend_credit_acc #(.MAX_CREDIT(MAX_CREDIT)) u_acc (
            .clock       (clock),
            .reset       (reset),
            .coin_valid  (coin_valid[i]),
            .coin_val    (coin_val[2*i +: 2]),
            .cancel      (cancel[i]),
            .busy        (busy[i]),
            .clear       (clear[i]),
            .credit      (credit[i]),
            .cancel_pend (pend[i]),
            .coin_reject (coin_reject[i])
        );
    end

    assign credit0 = credit[0];
    assign credit1 = credit[1];

    always_comb begin
        busy[0]  = (state != IDLE) && !grant;
        busy[1]  = (state != IDLE) && grant;
        clear[0] = (state == CHANGE) && !grant;
        clear[1] = (state == CHANGE) && grant;
        for (int i = 0; i < 2; i++)
            ready[i] = !busy[i] && ((credit[i] >= PRICE_C) || pend[i]);
        // Both ready: the kiosk not served last wins.
        pick      = (ready == 2'b11) ? !rr_ptr : ready[1];
        credit_g  = credit[grant];
        timed_out = (timer == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 1'b0;
            rr_ptr  <= 1'b0;
            refund  <= 1'b0;
            timer   <= '0;
            chg_reg <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (|ready) begin
                        grant  <= pick;
                        refund <= pend[pick];
                        state  <= pend[pick] ? CHANGE : DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (disp_ack) begin
                        chg_reg <= credit_g - PRICE_C;
                        state   <= CHANGE;
                    end else if (timed_out) begin
                        chg_reg <= credit_g;
                        state   <= CHANGE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                CHANGE: begin
                    rr_ptr <= grant;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Refunds read the live credit: it is frozen while busy and includes any coin taken at the grant edge.
    always_comb begin
        in_change     = (state == CHANGE);
        change_amount = refund ? credit_g : chg_reg;
        disp_req      = (state == DISPENSE);
        disp_kiosk    = disp_req && grant;
        fault         = disp_req && !disp_ack && timed_out;
        chg_amt       = in_change ? change_amount : 5'd0;
        chg_valid     = in_change && (change_amount != 5'd0);
        chg_kiosk     = in_change && grant;
    end

endmodule

// File: tb/tb_vend_scheduler.sv
// Directed bench for vend_scheduler: per-scenario tasks with hand-computed expectations.
module tb_vend_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] coin_valid;
    logic [3:0] coin_val;
    logic [1:0] cancel;
    logic       disp_ack;
    logic [1:0] coin_reject;
    logic [4:0] credit0;
    logic [4:0] credit1;
    logic [1:0] busy;
    logic       disp_req;
    logic       disp_kiosk;
    logic       chg_valid;
    logic [4:0] chg_amt;
    logic       chg_kiosk;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    vend_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .cancel      (cancel),
        .coin_reject (coin_reject),
        .credit0     (credit0),
        .credit1     (credit1),
        .busy        (busy),
        .disp_req    (disp_req),
        .disp_kiosk  (disp_kiosk),
        .disp_ack    (disp_ack),
        .chg_valid   (chg_valid),
        .chg_amt     (chg_amt),
        .chg_kiosk   (chg_kiosk),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; coin_valid = 2'b00; coin_val = 4'b0000; cancel = 2'b00; disp_ack = 1'b0;
        tick; tick;
        n_checks++;
        if ({coin_reject, credit0, credit1, busy, disp_req, disp_kiosk, chg_valid, chg_amt, chg_kiosk, fault} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                {coin_reject, credit0, credit1, busy, disp_req, disp_kiosk, chg_valid, chg_amt, chg_kiosk, fault});
        end
        reset = 1'b0;
        tick;
        n_checks++;
        if (disp_req !== 1'b0 || busy !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle: disp_req=%b busy=%b want 0/00", disp_req, busy);
        end
    endtask

    task automatic test_kiosk0_exact;
        coin_valid = 2'b01; coin_val = 4'b0010; tick;
        n_checks++;
        if (credit0 !== 5'd10) begin n_fail++; $display("FAIL k0_credit10: got %0d want 10", credit0); end
        coin_val = 4'b0001; tick;
        coin_valid = 2'b00; coin_val = 4'b0000;
        n_checks++;
        if (credit0 !== 5'd15 || disp_req !== 1'b0) begin
            n_fail++; $display("FAIL k0_credit15: credit0=%0d disp_req=%b want 15/0", credit0, disp_req);
        end
        tick;
        n_checks++;
        if (disp_req !== 1'b1 || disp_kiosk !== 1'b0 || busy !== 2'b01) begin
            n_fail++; $display("FAIL k0_dispense: req=%b kiosk=%b busy=%b want 1/0/01", disp_req, disp_kiosk, busy);
        end
        disp_ack = 1'b1; tick; disp_ack = 1'b0;
        n_checks++;
        if (chg_valid !== 1'b0 || busy !== 2'b01 || disp_req !== 1'b0) begin
            n_fail++; $display("FAIL k0_change: chg_valid=%b busy=%b req=%b want 0/01/0", chg_valid, busy, disp_req);
        end
        tick;
        n_checks++;
        if (credit0 !== 5'd0 || busy !== 2'b00) begin
            n_fail++; $display("FAIL k0_done: credit0=%0d busy=%b want 0/00", credit0, busy);
        end
    endtask

    task automatic test_kiosk1_change;
        coin_valid = 2'b10; coin_val = 4'b1000; tick; tick;
        coin_valid = 2'b00; coin_val = 4'b0000;
        n_checks++;
        if (credit1 !== 5'd20) begin n_fail++; $display("FAIL k1_credit: got %0d want 20", credit1); end
        tick;
        n_checks++;
        if (disp_req !== 1'b1 || disp_kiosk !== 1'b1) begin
            n_fail++; $display("FAIL k1_dispense: req=%b kiosk=%b want 1/1", disp_req, disp_kiosk);
        end
        disp_ack = 1'b1; tick; disp_ack = 1'b0;
        n_checks++;
        if (chg_valid !== 1'b1 || chg_amt !== 5'd5 || chg_kiosk !== 1'b1) begin
            n_fail++; $display("FAIL k1_change: valid=%b amt=%0d kiosk=%b want 1/5/1", chg_valid, chg_amt, chg_kiosk);
        end
        tick;
        n_checks++;
        if (credit1 !== 5'd0 || chg_valid !== 1'b0) begin
            n_fail++; $display("FAIL k1_done: credit1=%0d chg_valid=%b want 0/0", credit1, chg_valid);
        end
    endtask

    task automatic test_round_robin;
        reset = 1'b1; tick; reset = 1'b0;
        coin_valid = 2'b11; coin_val = 4'b1010; tick;
        coin_val = 4'b0101; tick;
        coin_valid = 2'b00; coin_val = 4'b0000;
        tick;
        n_checks++;
        if (disp_kiosk !== 1'b1 || busy !== 2'b10) begin
            n_fail++; $display("FAIL rr_first: kiosk=%b busy=%b want 1/10", disp_kiosk, busy);
        end
        disp_ack = 1'b1; tick; disp_ack = 1'b0;
        n_checks++;
        if (chg_valid !== 1'b0 || busy !== 2'b10) begin
            n_fail++; $display("FAIL rr_first_change: chg_valid=%b busy=%b want 0/10", chg_valid, busy);
        end
        tick;
        n_checks++;
        if (busy !== 2'b00 || credit1 !== 5'd0 || credit0 !== 5'd15) begin
            n_fail++; $display("FAIL rr_between: busy=%b c0=%0d c1=%0d want 00/15/0", busy, credit0, credit1);
        end
        tick;
        n_checks++;
        if (disp_req !== 1'b1 || disp_kiosk !== 1'b0 || busy !== 2'b01) begin
            n_fail++; $display("FAIL rr_second: req=%b kiosk=%b busy=%b want 1/0/01", disp_req, disp_kiosk, busy);
        end
        disp_ack = 1'b1; tick; disp_ack = 1'b0;
        tick;
        n_checks++;
        if (credit0 !== 5'd0 || busy !== 2'b00) begin
            n_fail++; $display("FAIL rr_done: credit0=%0d busy=%b want 0/00", credit0, busy);
        end
    endtask

    task automatic test_cancel;
        coin_valid = 2'b01; coin_val = 4'b0010; tick;
        coin_valid = 2'b00; coin_val = 4'b0000;
        cancel = 2'b01; tick; cancel = 2'b00;
        n_checks++;
        if (disp_req !== 1'b0 || credit0 !== 5'd10) begin
            n_fail++; $display("FAIL cancel_pend: req=%b credit0=%0d want 0/10", disp_req, credit0);
        end
        tick;
        n_checks++;
        if (disp_req !== 1'b0 || chg_valid !== 1'b1 || chg_amt !== 5'd10 || chg_kiosk !== 1'b0 || busy !== 2'b01) begin
            n_fail++;
            $display("FAIL cancel_refund: req=%b valid=%b amt=%0d kiosk=%b busy=%b want 0/1/10/0/01",
                disp_req, chg_valid, chg_amt, chg_kiosk, busy);
        end
        coin_valid = 2'b01; coin_val = 4'b0001; tick;
        coin_valid = 2'b00; coin_val = 4'b0000;
        n_checks++;
        if (coin_reject !== 2'b01 || credit0 !== 5'd0) begin
            n_fail++; $display("FAIL busy_coin: reject=%b credit0=%0d want 01/0", coin_reject, credit0);
        end
        tick;
        n_checks++;
        if (coin_reject !== 2'b00) begin n_fail++; $display("FAIL reject_pulse: got %b want 00", coin_reject); end
    endtask

    task automatic test_timeout;
        disp_ack = 1'b1; tick; disp_ack = 1'b0;
        n_checks++;
        if (disp_req !== 1'b0 || chg_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack: req=%b chg_valid=%b want 0/0", disp_req, chg_valid);
        end
        coin_valid = 2'b10; coin_val = 4'b1000; tick; tick;
        coin_valid = 2'b00; coin_val = 4'b0000;
        tick;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (disp_req !== 1'b1 || fault !== (i == 7)) begin
                n_fail++; $display("FAIL timeout_cycle%0d: req=%b fault=%b want 1/%b", i, disp_req, fault, (i == 7));
            end
            tick;
        end
        n_checks++;
        if (disp_req !== 1'b0 || fault !== 1'b0 || chg_valid !== 1'b1 || chg_amt !== 5'd20 || chg_kiosk !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_refund: req=%b fault=%b valid=%b amt=%0d kiosk=%b want 0/0/1/20/1",
                disp_req, fault, chg_valid, chg_amt, chg_kiosk);
        end
        tick;
        n_checks++;
        if (busy !== 2'b00 || credit1 !== 5'd0) begin
            n_fail++; $display("FAIL timeout_idle: busy=%b credit1=%0d want 00/0", busy, credit1);
        end
    endtask

    task automatic test_overflow_and_reset;
        coin_valid = 2'b10; coin_val = 4'b1000; tick;
        coin_val = 4'b0100; tick;
        coin_valid = 2'b00; coin_val = 4'b0000;
        tick;
        n_checks++;
        if (disp_req !== 1'b1 || disp_kiosk !== 1'b1) begin
            n_fail++; $display("FAIL ovf_k1_dispense: req=%b kiosk=%b want 1/1", disp_req, disp_kiosk);
        end
        coin_valid = 2'b01; coin_val = 4'b0010; tick; tick; tick;
        n_checks++;
        if (credit0 !== 5'd30 || busy !== 2'b10) begin
            n_fail++; $display("FAIL ovf_credit30: credit0=%0d busy=%b want 30/10", credit0, busy);
        end
        coin_val = 4'b0001; tick;
        coin_valid = 2'b00; coin_val = 4'b0000;
        n_checks++;
        if (coin_reject !== 2'b01 || credit0 !== 5'd30) begin
            n_fail++; $display("FAIL ovf_reject: reject=%b credit0=%0d want 01/30", coin_reject, credit0);
        end
        disp_ack = 1'b1; tick; disp_ack = 1'b0;
        tick; tick;
        n_checks++;
        if (disp_req !== 1'b1 || disp_kiosk !== 1'b0) begin
            n_fail++; $display("FAIL ovf_k0_dispense: req=%b kiosk=%b want 1/0", disp_req, disp_kiosk);
        end
        reset = 1'b1; tick;
        n_checks++;
        if ({coin_reject, credit0, credit1, busy, disp_req, disp_kiosk, chg_valid, chg_amt, chg_kiosk, fault} !== 27'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h want 0",
                {coin_reject, credit0, credit1, busy, disp_req, disp_kiosk, chg_valid, chg_amt, chg_kiosk, fault});
        end
        reset = 1'b0; tick;
        n_checks++;
        if (disp_req !== 1'b0 || chg_valid !== 1'b0 || busy !== 2'b00) begin
            n_fail++; $display("FAIL post_reset: req=%b valid=%b busy=%b want 0/0/00", disp_req, chg_valid, busy);
        end
    endtask

    initial begin
        test_reset;
        test_kiosk0_exact;
        test_kiosk1_change;
        test_round_robin;
        test_cancel;
        test_timeout;
        test_overflow_and_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
